pulse_period_meter: RTL and testbench

- Receive-side counterpart of the clock generator.
- Measures the period of an external pulse train (wheel-encoder output or a generated clock) against the shared free-running 32-bit `count` timebase.
- Reports each completed period with a one-cycle `valid` strobe and flags stalled inputs.
- Sits in the Position path between the encoder pins and the odometry/speed logic.

---
 rtl/position_pkg.sv | 12 +
 rtl/sync_edge_det.sv | 41 ++++
 rtl/pulse_period_meter.sv | 139 +++++++++++++
 tb/tb_pulse_period_meter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/position_pkg.sv
// Shared definitions for the Position path: meter FSM encoding and timebase width.
package position_pkg;

  localparam int unsigned COUNT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

endpackage : position_pkg

// File: rtl/sync_edge_det.sv
// Synchronizer chain plus history flop for an asynchronous pulse input.
// Optional macro PULSE_PERIOD_METER_HIGH_TIME_EN adds the falling-edge output.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  ,
  output logic fall
`endif
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  // Shift the input through the chain; history trails the newest synced bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  // Chain and history registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;
`endif

endmodule : sync_edge_det

// File: rtl/pulse_period_meter.sv
// Measures rising-to-rising period of sig_in against the shared count timebase.
// Optional macro PULSE_PERIOD_METER_HIGH_TIME_EN adds the high_time output.
module pulse_period_meter
  import position_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sig_in,
  input  logic [COUNT_W-1:0]    count,
  input  logic [COUNT_W-1:0]    timeout,
  output logic [COUNT_W-1:0]    period,
  output logic                  valid,
  output logic                  stalled,
  output logic [EDGE_CNT_W-1:0] edge_cnt
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [COUNT_W-1:0]    high_time
`endif
);

  meter_state_e          state_q, state_d;
  logic [COUNT_W-1:0]    stamp_q, stamp_d;
  logic [COUNT_W-1:0]    period_q, period_d;
  logic                  valid_q, valid_d;
  logic                  stalled_q, stalled_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [COUNT_W-1:0]    elapsed;
  logic                  tmo_hit;
  logic                  rise;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  logic                  fall;
  logic [COUNT_W-1:0]    high_time_q, high_time_d;
`endif

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .rise  (rise)
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    ,
    .fall  (fall)
`endif
  );

  // Modular difference keeps count wrap-around transparent.
  assign elapsed = count - stamp_q;
  assign tmo_hit = (timeout != '0) && (elapsed > timeout);

  // Next-state and output computation; rise takes priority over timeout.
  always_comb begin
    state_d    = state_q;
    stamp_d    = stamp_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    stalled_d  = stalled_q;
    edge_cnt_d = edge_cnt_q;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    high_time_d = high_time_q;
`endif
    if (!en) begin
      state_d   = IDLE;
      stalled_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = ARM;
          stalled_d = 1'b0;
        end
        ARM: begin
          if (rise) begin
            stamp_d    = count;
            edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
            state_d    = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d   = elapsed;
            stamp_d    = count;
            valid_d    = 1'b1;
            stalled_d  = 1'b0;
            edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
          end else if (tmo_hit) begin
            stalled_d = 1'b1;
            period_d  = '0;
            state_d   = ARM;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
            high_time_d = '0;
          end else if (fall) begin
            high_time_d = elapsed;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stamp_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stalled_q  <= 1'b0;
      edge_cnt_q <= '0;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
      high_time_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stamp_q    <= stamp_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stalled_q  <= stalled_d;
      edge_cnt_q <= edge_cnt_d;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
      high_time_q <= high_time_d;
`endif
    end
  end

  assign period   = period_q;
  assign valid    = valid_q;
  assign stalled  = stalled_q;
  assign edge_cnt = edge_cnt_q;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  assign high_time = high_time_q;
`endif

endmodule : pulse_period_meter

// File: tb/tb_pulse_period_meter.sv
// Directed self-checking bench for pulse_period_meter (SYNC_STAGES=2).
module tb_pulse_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] count = 32'd0;
  logic [31:0] timeout = 32'd0;
  logic [31:0] period;
  logic        valid;
  logic        stalled;
  logic [15:0] edge_cnt;
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
  logic [31:0] high_time;
`endif

  int checks = 0;
  int failures = 0;
  int exp_edges = 0;

  // Pattern generator state: sig_in high for gen_hi of every gen_per cycles.
  bit gen_on = 1'b0;
  int gen_per = 100;
  int gen_hi = 30;
  int ph = 0;

  pulse_period_meter #(
    .SYNC_STAGES(2),
    .EDGE_CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sig_in   (sig_in),
    .count    (count),
    .timeout  (timeout),
    .period   (period),
    .valid    (valid),
    .stalled  (stalled),
    .edge_cnt (edge_cnt)
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    ,
    .high_time(high_time)
`endif
  );

  always #5 clk = ~clk;

  // One clock: sample point is 1ns after the edge, then inputs for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    count = count + 32'd1;
    if (gen_on) begin
      sig_in = (ph < gen_hi);
      ph = (ph + 1 == gen_per) ? 0 : ph + 1;
    end
  endtask

  task automatic one_pulse();
    sig_in = 1'b1;
    tick();
    sig_in = 1'b0;
  endtask

  task automatic restart_gen(input int per, input int hi);
    gen_per = per;
    gen_hi  = hi;
    ph      = 0;
    gen_on  = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with sig_in toggling
    rst_n = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sig_in = ~sig_in;
      tick();
    end
    sig_in = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_period", period, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_stalled", {31'd0, stalled}, 32'd0);
    chk("rst_edge_cnt", {16'd0, edge_cnt}, 32'd0);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    chk("rst_high_time", high_time, 32'd0);
`endif

    // Steady period 100, 30% duty, no timeout
    count = 32'd1000;
    timeout = 32'd0;
    en = 1'b1;
    repeat (3) tick();
    restart_gen(100, 30);
    tick();                       // sig_in high for edge k
    tick();                       // edge k
    tick();                       // edge k+1
    chk("lat_edge_cnt_k1", {16'd0, edge_cnt}, 32'd0);
    tick();                       // edge k+2
    exp_edges++;
    chk("lat_edge_cnt_k2", {16'd0, edge_cnt}, exp_edges);
    chk("first_rise_no_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (99) tick();
      chk("steady_pre_valid", {31'd0, valid}, 32'd0);
      tick();
      exp_edges++;
      chk("steady_valid", {31'd0, valid}, 32'd1);
      chk("steady_period", period, 32'd100);
      chk("steady_edge_cnt", {16'd0, edge_cnt}, exp_edges);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
      chk("steady_high_time", high_time, 32'd30);
`endif
    end
    tick();
    chk("valid_one_cycle", {31'd0, valid}, 32'd0);
    chk("steady_no_stall", {31'd0, stalled}, 32'd0);

    // Period measured across count wrap-around
    gen_on = 1'b0;
    sig_in = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    count = 32'hFFFF_FFC0;
    en = 1'b1;
    restart_gen(100, 30);
    tick();
    repeat (2) tick();
    tick();
    exp_edges++;
    chk("wrap_first_no_valid", {31'd0, valid}, 32'd0);
    repeat (100) tick();
    exp_edges++;
    chk("wrap_valid", {31'd0, valid}, 32'd1);
    chk("wrap_period", period, 32'd100);
    chk("wrap_edge_cnt", {16'd0, edge_cnt}, exp_edges);

    // Timeout after a single rise
    gen_on = 1'b0;
    sig_in = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    count = 32'd5000;
    timeout = 32'd500;
    en = 1'b1;
    tick();
    one_pulse();                  // edge k
    tick();                       // k+1
    tick();                       // k+2: stamp
    exp_edges++;
    chk("tmo_arm_edge_cnt", {16'd0, edge_cnt}, exp_edges);
    repeat (500) tick();          // elapsed 500 evaluated
    chk("tmo_not_yet", {31'd0, stalled}, 32'd0);
    tick();                       // elapsed 501 evaluated
    chk("tmo_stalled", {31'd0, stalled}, 32'd1);
    chk("tmo_period_zero", period, 32'd0);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    chk("tmo_high_time_zero", high_time, 32'd0);
`endif
    one_pulse();
    tick();
    tick();
    exp_edges++;
    chk("rearm_no_valid", {31'd0, valid}, 32'd0);
    chk("rearm_still_stalled", {31'd0, stalled}, 32'd1);
    chk("rearm_edge_cnt", {16'd0, edge_cnt}, exp_edges);
    repeat (97) tick();
    one_pulse();
    tick();
    tick();
    exp_edges++;
    chk("recover_valid", {31'd0, valid}, 32'd1);
    chk("recover_period", period, 32'd100);
    chk("recover_stall_clear", {31'd0, stalled}, 32'd0);

    // Rise coincides with the first cycle elapsed exceeds timeout
    repeat (498) tick();
    one_pulse();
    tick();
    chk("tie_pre_stalled", {31'd0, stalled}, 32'd0);
    tick();
    exp_edges++;
    chk("tie_valid", {31'd0, valid}, 32'd1);
    chk("tie_period", period, 32'd501);
    chk("tie_stalled", {31'd0, stalled}, 32'd0);
    chk("tie_edge_cnt", {16'd0, edge_cnt}, exp_edges);

    // Drop en for one cycle mid-measurement
    timeout = 32'd0;
    repeat (50) tick();
    en = 1'b0;
    tick();
    chk("dis_valid", {31'd0, valid}, 32'd0);
    chk("dis_period_hold", period, 32'd501);
    en = 1'b1;
    tick();
    one_pulse();
    tick();
    tick();
    exp_edges++;
    chk("reen_no_valid", {31'd0, valid}, 32'd0);
    chk("reen_edge_cnt", {16'd0, edge_cnt}, exp_edges);
    repeat (97) tick();
    one_pulse();
    tick();
    tick();
    exp_edges++;
    chk("reen_valid", {31'd0, valid}, 32'd1);
    chk("reen_period", period, 32'd100);
    chk("reen_edge_cnt2", {16'd0, edge_cnt}, exp_edges);
`ifdef PULSE_PERIOD_METER_HIGH_TIME_EN
    tick();
    chk("reen_high_time", high_time, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse_period_meter
